// File: rtl/dsc_pkg.sv
// Shared types and default widths for the dsc_op_seq operation sequencer.
package dsc_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_INPUTS = 2;
    localparam int CNT_WIDTH  = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } dsc_state_e;

endpackage

// File: rtl/dsc_op_seq_if.sv
// Operand/result handshake bundle of dsc_op_seq; slave is the sequencer side.
interface dsc_op_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 2,
    parameter int CNT_WIDTH  = 17
);
    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [CNT_WIDTH-1:0]             cycle_budget;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]             out_cycles;
    logic                             out_truncated;

    modport master (
        output in_valid, in_data, cycle_budget, out_ready,
        input  in_ready, out_valid, out_data, out_cycles, out_truncated
    );

    modport slave (
        input  in_valid, in_data, cycle_budget, out_ready,
        output in_ready, out_valid, out_data, out_cycles, out_truncated
    );
endinterface

// File: rtl/dsc_cycle_ctr.sv
// Saturating run-cycle counter with enable and synchronous clear; exposes the
// incremented value so the sequencer can decide termination in the same cycle.
module dsc_cycle_ctr
    import dsc_pkg::*;
#(
    parameter int CNT_WIDTH = dsc_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] inc_o,
    output logic                 sat_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            inc_o = CNT_MAX;
        end else begin
            inc_o = cnt_q + CNT_WIDTH'(1);
        end
        sat_o = (inc_o == CNT_MAX);
        if (clr_i) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (en_i) begin
            cnt_d = inc_o;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dsc_op_seq.sv
// Sequences one operation on a downstream core: latch operands, clear, run until
// finish/budget/saturation, hold result. Optional stats via DSC_OP_SEQ_STATS_EN.
module dsc_op_seq
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = dsc_pkg::DATA_WIDTH,
    parameter int NUM_INPUTS = dsc_pkg::NUM_INPUTS,
    parameter int CNT_WIDTH  = dsc_pkg::CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    dsc_op_seq_if.slave                      bus,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
    input  logic                             core_op_finished
`ifdef DSC_OP_SEQ_STATS_EN
    ,
    output logic [31:0]                      stat_ops,
    output logic [47:0]                      stat_cycle_sum
`endif
);
    localparam int W = NUM_INPUTS * DATA_WIDTH;

    dsc_state_e state_q, state_d;
    logic in_ready_q, in_ready_d, core_rst_q, core_rst_d;
    logic core_en_q, core_en_d, out_valid_q, out_valid_d;
    logic [W-1:0]         core_data_in_q, out_data_q;
    logic [CNT_WIDTH-1:0] budget_q, out_cycles_q, inc_s;
    logic out_trunc_q, sat_s, run_s, accept_s, budget_hit_s, term_s, take_s;

    assign run_s        = (state_q == ST_RUN);
    assign accept_s     = (state_q == ST_IDLE) && bus.in_valid;
    assign budget_hit_s = (budget_q != {CNT_WIDTH{1'b0}}) && (inc_s == budget_q);
    assign term_s       = run_s && (core_op_finished || budget_hit_s || sat_s);
    assign take_s       = (state_q == ST_HOLD) && bus.out_ready;

    dsc_cycle_ctr #(.CNT_WIDTH(CNT_WIDTH)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept_s),
        .en_i  (run_s),
        .inc_o (inc_s),
        .sat_o (sat_s)
    );

    // Control outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept_s ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN:   state_d = term_s ? ST_HOLD : ST_RUN;
            ST_HOLD:  state_d = bus.out_ready ? ST_IDLE : ST_HOLD;
            default:  state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        core_rst_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        core_en_d   = (state_d == ST_RUN);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            in_ready_q     <= 1'b1;
            core_rst_q     <= 1'b1;
            core_en_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            core_data_in_q <= {W{1'b0}};
            budget_q       <= {CNT_WIDTH{1'b0}};
            out_data_q     <= {W{1'b0}};
            out_cycles_q   <= {CNT_WIDTH{1'b0}};
            out_trunc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            out_valid_q <= out_valid_d;
            if (accept_s) begin
                core_data_in_q <= bus.in_data;
                budget_q       <= bus.cycle_budget;
            end
            // Finish wins over a coincident budget/saturation hit.
            if (term_s) begin
                out_data_q   <= core_data_out;
                out_cycles_q <= inc_s;
                out_trunc_q  <= ~core_op_finished;
            end
        end
    end

`ifdef DSC_OP_SEQ_STATS_EN
    logic [31:0] stat_ops_q;
    logic [47:0] stat_sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= 32'd0;
            stat_sum_q <= 48'd0;
        end else if (take_s) begin
            stat_ops_q <= stat_ops_q + 32'd1;
            stat_sum_q <= stat_sum_q + 48'(out_cycles_q);
        end
    end

    assign stat_ops       = stat_ops_q;
    assign stat_cycle_sum = stat_sum_q;
`else
    logic unused_take_s;
    assign unused_take_s = take_s;
`endif

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_cycles    = out_cycles_q;
    assign bus.out_truncated = out_trunc_q;
    assign core_rst          = core_rst_q;
    assign core_en           = core_en_q;
    assign core_data_in      = core_data_in_q;
endmodule

// File: tb/tb_dsc_op_seq.sv
// Bench for dsc_op_seq: core model finishing after N enabled cycles, directed and
// random operations checked against a budget/finish reference model.
module tb_dsc_op_seq;
    logic        clk;
    logic        rst;
    logic        core_rst, core_en, core_op_finished;
    logic [15:0] core_data_in, core_data_out;
`ifdef DSC_OP_SEQ_STATS_EN
    logic [31:0] stat_ops;
    logic [47:0] stat_cycle_sum;
`endif

    dsc_op_seq_if #(.DATA_WIDTH(8), .NUM_INPUTS(2), .CNT_WIDTH(17)) bus ();

    dsc_op_seq #(.DATA_WIDTH(8), .NUM_INPUTS(2), .CNT_WIDTH(17)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .core_rst         (core_rst),
        .core_en          (core_en),
        .core_data_in     (core_data_in),
        .core_data_out    (core_data_out),
        .core_op_finished (core_op_finished)
`ifdef DSC_OP_SEQ_STATS_EN
        ,
        .stat_ops         (stat_ops),
        .stat_cycle_sum   (stat_cycle_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: counts enabled cycles since its last clear, finishes on the N-th.
    int       core_n;
    int       en_cnt;
    always @(posedge clk) begin
        if (core_rst) en_cnt <= 0;
        else if (core_en) en_cnt <= en_cnt + 1;
    end
    assign core_op_finished = core_en && (en_cnt == core_n - 1);
    assign core_data_out    = {8'(core_data_in[15:8] + core_data_in[7:0]), 8'(en_cnt)};

    int checks = 0;
    int errors = 0;
    longint exp_ops = 0;
    longint exp_sum = 0;

    // Observations collected by do_op for the calling test to judge.
    bit          obs_timeout, obs_stable, obs_hold_ok, obs_busy_ok, obs_din_ok;
    logic        obs_clear_rst, obs_clear_en, obs_prev_en, obs_en_at_valid;
    logic        obs_after_valid, obs_after_ready, obs_trunc;
    int          obs_lat, obs_en_cycles;
    logic [15:0] obs_data, obs_din_after;
    logic [16:0] obs_cycles;

    function automatic int exp_cycles(input logic [16:0] budget, input int n);
        if (budget != 17'd0 && int'(budget) < n) return int'(budget);
        return n;
    endfunction

    function automatic logic exp_trunc(input logic [16:0] budget, input int n);
        return (budget != 17'd0) && (int'(budget) < n);
    endfunction

    function automatic logic [15:0] exp_data(input logic [7:0] a, input logic [7:0] b, input int cyc);
        logic [7:0] s;
        s = a + b;
        return {s, 8'(cyc - 1)};
    endfunction

    // Must be called at a falling edge; returns at a falling edge after the handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [16:0] budget,
                         input int n, input int hold, input bit keep_valid);
        int k;
        int guard;
        logic prev_en;
        obs_timeout = 1'b0; obs_stable = 1'b1; obs_hold_ok = 1'b1; obs_busy_ok = 1'b1; obs_din_ok = 1'b1;
        obs_lat = -1; obs_en_cycles = 0;
        core_n = n;
        bus.in_valid = 1'b1; bus.in_data = {b, a}; bus.cycle_budget = budget;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk); guard++;
        end
        if (guard >= 100) begin
            obs_timeout = 1'b1; bus.in_valid = 1'b0; return;
        end
        @(negedge clk);
        if (!keep_valid) bus.in_valid = 1'b0;
        obs_clear_rst = core_rst; obs_clear_en = core_en;
        k = 1;
        while (k < 300) begin
            prev_en = core_en;
            @(negedge clk); k++;
            if (bus.out_valid === 1'b1) break;
            if (core_en === 1'b1) begin
                obs_en_cycles++;
                if (obs_lat < 0) obs_lat = k;
            end
            if (bus.in_ready !== 1'b0) obs_busy_ok = 1'b0;
            if (core_data_in !== {b, a}) obs_din_ok = 1'b0;
        end
        if (bus.out_valid !== 1'b1) begin
            obs_timeout = 1'b1; return;
        end
        obs_prev_en = prev_en; obs_en_at_valid = core_en;
        obs_data = bus.out_data; obs_cycles = bus.out_cycles; obs_trunc = bus.out_truncated;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== obs_data || bus.out_cycles !== obs_cycles
                || bus.out_truncated !== obs_trunc) obs_stable = 1'b0;
            if (bus.in_ready !== 1'b0 || core_en !== 1'b0 || core_rst !== 1'b0) obs_hold_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        obs_after_valid = bus.out_valid; obs_after_ready = bus.in_ready; obs_din_after = core_data_in;
        exp_ops++;
        exp_sum += longint'(exp_cycles(budget, n));
    endtask

    task automatic test_reset();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (core_en !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_ctl: got en=%b rst=%b expected en=0 rst=1", core_en, core_rst); end
        checks++; if (bus.out_data !== 16'h0 || bus.out_cycles !== 17'd0 || bus.out_truncated !== 1'b0)
            begin errors++; $display("FAIL rst_outs: got data=%h cyc=%0d tr=%b expected 0", bus.out_data, bus.out_cycles, bus.out_truncated); end
        checks++; if (core_data_in !== 16'h0) begin errors++; $display("FAIL rst_core_data_in: got %h expected 0", core_data_in); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (core_rst !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_hold_clear: got core_rst=%b in_ready=%b expected 1/1", core_rst, bus.in_ready); end
    endtask

    task automatic test_basic();
        do_op(8'h05, 8'h03, 17'd0, 15, 0, 1'b0);
        checks++; if (obs_timeout) begin errors++; $display("FAIL basic_timeout: got timeout expected result"); return; end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", obs_lat); end
        checks++; if (obs_clear_rst !== 1'b1 || obs_clear_en !== 1'b0) begin errors++; $display("FAIL basic_clear: got rst=%b en=%b expected 1/0", obs_clear_rst, obs_clear_en); end
        checks++; if (obs_en_cycles !== 15) begin errors++; $display("FAIL basic_en_cycles: got %0d expected 15", obs_en_cycles); end
        checks++; if (obs_prev_en !== 1'b1 || obs_en_at_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_timing: got prev_en=%b en=%b expected 1/0", obs_prev_en, obs_en_at_valid); end
        checks++; if (obs_cycles !== 17'd15 || obs_trunc !== 1'b0) begin errors++; $display("FAIL basic_result: got cyc=%0d tr=%b expected 15/0", obs_cycles, obs_trunc); end
        checks++; if (obs_data !== exp_data(8'h05, 8'h03, 15)) begin errors++; $display("FAIL basic_data: got %h expected %h", obs_data, exp_data(8'h05, 8'h03, 15)); end
        checks++; if (obs_busy_ok !== 1'b1 || obs_din_ok !== 1'b1) begin errors++; $display("FAIL basic_busy: got busy_ok=%b din_ok=%b expected 1/1", obs_busy_ok, obs_din_ok); end
        checks++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake: got valid=%b ready=%b expected 0/1", obs_after_valid, obs_after_ready); end
        checks++; if (obs_din_after !== 16'h0305) begin errors++; $display("FAIL basic_din_hold: got %h expected 0305", obs_din_after); end
    endtask

    task automatic test_budget();
        logic [16:0] bud [4] = '{17'd10, 17'd10, 17'd1, 17'd1};
        int          nn  [4] = '{40, 10, 5, 1};
        for (int i = 0; i < 4; i++) begin
            do_op(8'h20 + 8'(i), 8'h40, bud[i], nn[i], 0, 1'b0);
            checks++;
            if (obs_timeout || obs_cycles !== 17'(exp_cycles(bud[i], nn[i])) || obs_trunc !== exp_trunc(bud[i], nn[i])
                || obs_en_cycles !== exp_cycles(bud[i], nn[i])) begin
                errors++;
                $display("FAIL budget_%0d: got to=%b cyc=%0d tr=%b en=%0d expected cyc=%0d tr=%b", i, obs_timeout,
                         obs_cycles, obs_trunc, obs_en_cycles, exp_cycles(bud[i], nn[i]), exp_trunc(bud[i], nn[i]));
            end
            checks++;
            if (obs_data !== exp_data(8'h20 + 8'(i), 8'h40, exp_cycles(bud[i], nn[i]))) begin
                errors++; $display("FAIL budget_data_%0d: got %h expected %h", i, obs_data, exp_data(8'h20 + 8'(i), 8'h40, exp_cycles(bud[i], nn[i])));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_op(8'h7a, 8'h11, 17'd0, 8, 5, 1'b1);
        checks++; if (obs_timeout || obs_stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got to=%b stable=%b expected 0/1", obs_timeout, obs_stable); end
        checks++; if (obs_hold_ok !== 1'b1) begin errors++; $display("FAIL bp_no_second_op: got hold_ok=%b expected 1", obs_hold_ok); end
        checks++; if (obs_after_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", obs_after_ready); end
        do_op(8'h7a, 8'h11, 17'd0, 8, 0, 1'b0);
        checks++; if (obs_timeout || obs_cycles !== 17'd8 || obs_data !== exp_data(8'h7a, 8'h11, 8))
            begin errors++; $display("FAIL bp_second: got to=%b cyc=%0d data=%h expected cyc=8 data=%h", obs_timeout, obs_cycles, obs_data, exp_data(8'h7a, 8'h11, 8)); end
    endtask

    task automatic test_reset_mid_run();
        int guard;
        bit seen_valid;
        core_n = 40;
        bus.in_valid = 1'b1; bus.in_data = 16'h2211; bus.cycle_budget = 17'd0;
        guard = 0;
        while (core_en !== 1'b1 && guard < 50) begin
            @(negedge clk); guard++;
            if (bus.in_ready !== 1'b1) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (guard >= 50 || core_en !== 1'b1) begin errors++; $display("FAIL midrst_reach_run: got core_en=%b expected 1", core_en); end
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || core_en !== 1'b0 || core_rst !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_idle: got rdy=%b en=%b crst=%b vld=%b expected 1/0/1/0", bus.in_ready, core_en, core_rst, bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++; if (seen_valid) begin errors++; $display("FAIL midrst_no_valid: got out_valid seen expected none"); end
        do_op(8'h11, 8'h22, 17'd0, 6, 0, 1'b0);
        checks++; if (obs_timeout || obs_cycles !== 17'd6 || obs_trunc !== 1'b0 || obs_data !== exp_data(8'h11, 8'h22, 6))
            begin errors++; $display("FAIL midrst_next_op: got to=%b cyc=%0d tr=%b data=%h expected 6/0/%h", obs_timeout, obs_cycles, obs_trunc, obs_data, exp_data(8'h11, 8'h22, 6)); end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [16:0] budget;
        int          n, ec;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            n = int'($urandom_range(1, 40));
            budget = ($urandom_range(0, 2) == 0) ? 17'd0 : 17'($urandom_range(1, 45));
            ec = exp_cycles(budget, n);
            do_op(a, b, budget, n, int'($urandom_range(0, 3)), 1'b0);
            checks++;
            if (obs_timeout || obs_cycles !== 17'(ec) || obs_trunc !== exp_trunc(budget, n) || obs_data !== exp_data(a, b, ec)
                || obs_stable !== 1'b1 || obs_lat !== 2) begin
                errors++;
                $display("FAIL random_%0d: got to=%b cyc=%0d tr=%b data=%h lat=%0d stable=%b expected cyc=%0d tr=%b data=%h lat=2 (n=%0d budget=%0d)",
                         i, obs_timeout, obs_cycles, obs_trunc, obs_data, obs_lat, obs_stable, ec, exp_trunc(budget, n), exp_data(a, b, ec), n, budget);
            end
        end
    endtask

`ifdef DSC_OP_SEQ_STATS_EN
    task automatic test_stats();
        checks++; if (stat_ops !== 32'(exp_ops) || stat_cycle_sum !== 48'(exp_sum))
            begin errors++; $display("FAIL stats_running: got ops=%0d sum=%0d expected %0d/%0d", stat_ops, stat_cycle_sum, exp_ops, exp_sum); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_ops = 0; exp_sum = 0;
        do_op(8'h01, 8'h02, 17'd0, 15, 0, 1'b0);
        do_op(8'h03, 8'h04, 17'd0, 10, 0, 1'b0);
        do_op(8'h05, 8'h06, 17'd0, 7, 0, 1'b0);
        checks++; if (stat_ops !== 32'd3 || stat_cycle_sum !== 48'd32)
            begin errors++; $display("FAIL stats_three_ops: got ops=%0d sum=%0d expected 3/32", stat_ops, stat_cycle_sum); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        core_n = 1;
        bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.cycle_budget = 17'd0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_budget();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef DSC_OP_SEQ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
